// File: rtl/bus_op_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : bus_op_scheduler
// Purpose  : Queues Pi-side bus commands and presents them one at a time to
//            the 68K bus engine. Writes go through a small FIFO and a single
//            read is held until every earlier write has been issued, so bus
//            order always matches Pi order. Read data is returned as a
//            one-cycle pulse.
// Options  : WRITE_POST_EN - when defined, writes are posted into a DEPTH-entry
//            FIFO. When undefined, only one write may be outstanding, and it
//            holds cmd_ready low until its bus cycle completes.
// Revision : 1.0 - initial release
// ============================================================================
module bus_op_scheduler #(
  parameter int DEPTH = 4
) (
  input  logic        m68k_clk,
  input  logic        op_txnrst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic        cmd_sz,
  input  logic [23:0] cmd_a,
  input  logic [15:0] cmd_d,
  output logic        op_req,
  output logic        op_rw,
  output logic        op_sz,
  output logic [23:0] op_a,
  output logic [15:0] op_d,
  input  logic        op_done,
  input  logic [15:0] op_din,
  output logic        rd_valid,
  output logic [15:0] rd_data,
  output logic        txn_busy,
  input  logic        flush
);

  // Pointer and occupancy widths. The count needs one extra bit so that a
  // full FIFO can be told apart from an empty one.
  localparam int c_pw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cw = c_pw + 1;

`ifdef WRITE_POST_EN
  localparam int c_cap = DEPTH;
`else
  // Without posting, one write at a time occupies the queue.
  localparam int c_cap = 1;
`endif

  localparam logic [c_cw-1:0] c_cap_cnt = c_cw'(c_cap);
  localparam logic [c_cw-1:0] c_cnt_one = c_cw'(1);
  localparam logic [c_pw-1:0] c_ptr_one = c_pw'(1);

  // Scheduler states
  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_issue = 2'd1;
  localparam logic [1:0] c_st_wait  = 2'd2;
  localparam logic [1:0] c_st_rret  = 2'd3;

  logic [1:0]      r_state;
  logic [c_cw-1:0] r_cnt;
  logic [c_pw-1:0] r_wptr;
  logic [c_pw-1:0] r_rptr;

  // Write FIFO storage
  logic [23:0]     r_fa [0:DEPTH-1];
  logic            r_fs [0:DEPTH-1];
  logic [15:0]     r_fd [0:DEPTH-1];

  // Single read-hold register
  logic            r_hold_v;
  logic [23:0]     r_hold_a;
  logic            r_hold_sz;

  // Source of the operation currently on the bus (1 = read hold)
  logic            r_op_is_rd;
  // A flush arrived while a bus cycle was in flight
  logic            r_flush_pend;
  logic [15:0]     r_rd_data;
  // Low during reset and for the cycle of release; gates cmd_ready/txn_busy
  logic            r_live;

  logic            w_fifo_empty;
  logic            w_fifo_full;
  logic            w_accept;
  logic            w_push;
  logic            w_hold_set;
  logic            w_done;
  logic            w_pop;
  logic            w_active;
  logic            w_sel_rd;
  logic            w_flush_all;
  logic [c_cw-1:0] w_cnt_nxt;

  assign w_fifo_empty = (r_cnt == '0);
  assign w_fifo_full  = (r_cnt == c_cap_cnt);

  // Commands are accepted only outside RRET, with room in the queue and no
  // read already parked.
  assign cmd_ready  = r_live && !w_fifo_full && !r_hold_v && (r_state != c_st_rret);
  assign w_accept   = cmd_valid && cmd_ready;
  assign w_push     = w_accept && !cmd_rw && !flush;
  assign w_hold_set = w_accept &&  cmd_rw && !flush;

  // OP_DONE only means something while a bus cycle is outstanding.
  assign w_done = (r_state == c_st_wait) && op_done;
  assign w_pop  = w_done && !r_op_is_rd;

  // A flush takes effect at once unless a bus cycle is still running; in that
  // case it is deferred until the engine reports completion.
  assign w_flush_all = flush && ((r_state != c_st_wait) || op_done);

  assign w_active = (r_state == c_st_issue) || (r_state == c_st_wait);
  // Writes win in ISSUE; the read hold is used only once the FIFO is drained.
  assign w_sel_rd = (r_state == c_st_issue) ? w_fifo_empty : r_op_is_rd;

  assign txn_busy = r_live && (!cmd_ready || r_hold_v);
  assign rd_valid = (r_state == c_st_rret);
  assign rd_data  = r_rd_data;

  // Next FIFO occupancy; a push and pop together leave it unchanged.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_push && !w_pop) begin
      w_cnt_nxt = r_cnt + c_cnt_one;
    end else if (!w_push && w_pop) begin
      w_cnt_nxt = r_cnt - c_cnt_one;
    end
  end

  // Drive the bus request fields from the FIFO head or the read hold.
  always_comb begin
    op_req = 1'b0;
    op_rw  = 1'b0;
    op_sz  = 1'b0;
    op_a   = '0;
    op_d   = '0;
    if (w_active) begin
      op_req = 1'b1;
      if (w_sel_rd) begin
        op_rw = 1'b1;
        op_sz = r_hold_sz;
        op_a  = r_hold_a;
      end else begin
        op_sz = r_fs[r_rptr];
        op_a  = r_fa[r_rptr];
        op_d  = r_fd[r_rptr];
      end
    end
  end

  // Write FIFO storage; contents need no reset because occupancy guards them.
  always_ff @(posedge m68k_clk) begin
    if (w_push) begin
      r_fa[r_wptr] <= cmd_a;
      r_fs[r_wptr] <= cmd_sz;
      r_fd[r_wptr] <= cmd_d;
    end
  end

  // Control state, FIFO pointers, read hold and read-return capture.
  always_ff @(posedge m68k_clk or posedge op_txnrst) begin
    if (op_txnrst) begin
      r_state      <= c_st_idle;
      r_cnt        <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_hold_v     <= 1'b0;
      r_hold_a     <= '0;
      r_hold_sz    <= 1'b0;
      r_op_is_rd   <= 1'b0;
      r_flush_pend <= 1'b0;
      r_rd_data    <= '0;
      r_live       <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_flush_all) begin
        r_state      <= c_st_idle;
        r_cnt        <= '0;
        r_wptr       <= '0;
        r_rptr       <= '0;
        r_hold_v     <= 1'b0;
        r_flush_pend <= 1'b0;
      end else if (flush) begin
        // In WAIT with the cycle still running: keep only the entry on the
        // bus so the OP_* fields stay stable, drop everything queued behind.
        r_flush_pend <= 1'b1;
        if (r_op_is_rd) begin
          r_cnt  <= '0;
          r_wptr <= r_rptr;
        end else begin
          r_cnt  <= c_cnt_one;
          r_wptr <= r_rptr + c_ptr_one;
        end
      end else begin
        if (w_push) begin
          r_wptr <= r_wptr + c_ptr_one;
        end
        if (w_pop) begin
          r_rptr <= r_rptr + c_ptr_one;
        end
        r_cnt <= w_cnt_nxt;

        if (w_hold_set) begin
          r_hold_v  <= 1'b1;
          r_hold_a  <= cmd_a;
          r_hold_sz <= cmd_sz;
        end

        case (r_state)
          c_st_idle: begin
            if (!w_fifo_empty || r_hold_v) begin
              r_state <= c_st_issue;
            end
          end
          c_st_issue: begin
            r_op_is_rd <= w_fifo_empty;
            r_state    <= c_st_wait;
          end
          c_st_wait: begin
            if (op_done) begin
              if (r_flush_pend) begin
                // Deferred flush: the in-flight op has finished, drop it.
                r_flush_pend <= 1'b0;
                if (r_op_is_rd) begin
                  r_hold_v <= 1'b0;
                end
                r_state <= c_st_idle;
              end else if (r_op_is_rd) begin
                r_rd_data <= op_din;
                r_state   <= c_st_rret;
              end else if ((w_cnt_nxt != '0) || r_hold_v || w_hold_set) begin
                r_state <= c_st_issue;
              end else begin
                r_state <= c_st_idle;
              end
            end
          end
          c_st_rret: begin
            r_hold_v <= 1'b0;
            r_state  <= c_st_idle;
          end
          default: begin
            r_state <= c_st_idle;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_op_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_op_scheduler
// Purpose  : Self-checking bench for bus_op_scheduler. Directed steps cover
//            reset, ordering, flush and the posting option; a random phase
//            checks bus order and read returns against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_op_scheduler;

  typedef struct packed {
    logic        rw;
    logic        sz;
    logic [23:0] a;
    logic [15:0] d;
  } op_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_rw = 1'b0;
  logic        cmd_sz = 1'b0;
  logic [23:0] cmd_a = '0;
  logic [15:0] cmd_d = '0;
  logic        flush = 1'b0;
  logic        cmd_ready;
  logic        op_req;
  logic        op_rw;
  logic        op_sz;
  logic [23:0] op_a;
  logic [15:0] op_d;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        txn_busy;

  // Bus-engine side: manual drive from the directed steps, or an automatic
  // responder with random latency for the random phase.
  logic        auto_bus = 1'b0;
  logic        m_done = 1'b0;
  logic [15:0] m_din = '0;
  logic        a_done = 1'b0;
  logic [15:0] a_din = '0;
  logic        op_done;
  logic [15:0] op_din;
  assign op_done = auto_bus ? a_done : m_done;
  assign op_din  = auto_bus ? a_din  : m_din;

  int checks = 0;
  int errors = 0;
  int rd_pulses = 0;

  // Model: every accepted command becomes exactly one bus op, in Pi order;
  // every read returns the data the engine supplied for it.
  op_t         exp_ops[$];
  logic [15:0] exp_rd[$];

  always #5 clk = ~clk;

  bus_op_scheduler #(.DEPTH(4)) dut (
    .m68k_clk (clk),
    .op_txnrst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_rw   (cmd_rw),
    .cmd_sz   (cmd_sz),
    .cmd_a    (cmd_a),
    .cmd_d    (cmd_d),
    .op_req   (op_req),
    .op_rw    (op_rw),
    .op_sz    (op_sz),
    .op_a     (op_a),
    .op_d     (op_d),
    .op_done  (op_done),
    .op_din   (op_din),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .txn_busy (txn_busy),
    .flush    (flush)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic rw, input logic sz, input logic [23:0] a, input logic [15:0] d);
    int n;
    n = 0;
    while (!cmd_ready && n < 300) begin
      cyc();
      n++;
    end
    chk("send_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_rw = rw;
    cmd_sz = sz;
    cmd_a = a;
    cmd_d = d;
    if (auto_bus) exp_ops.push_back(op_t'{rw, sz, a, (rw ? 16'h0 : d)});
    cyc();
    cmd_valid = 1'b0;
  endtask

  // Wait for a request, let it reach WAIT, capture its fields, complete it.
  task automatic bus_done(input logic [15:0] din, output logic [23:0] a,
                          output logic rw, output logic [15:0] d);
    int n;
    n = 0;
    while (!op_req && n < 100) begin
      cyc();
      n++;
    end
    chk("bus_req_seen", op_req, 1);
    cyc();
    a = op_a;
    rw = op_rw;
    d = op_d;
    m_done = 1'b1;
    m_din = din;
    cyc();
    m_done = 1'b0;
  endtask

  // Automatic bus engine and read-return monitor.
  int  wcnt = 0;
  int  lat = 0;
  op_t e;
  always begin
    @(posedge clk);
    #1;
    if (rd_valid) begin
      rd_pulses++;
      if (auto_bus) begin
        if (exp_rd.size() == 0) chk("rd_unexpected", rd_valid, 0);
        else chk("rd_data", rd_data, exp_rd.pop_front());
      end
    end
    if (a_done) begin
      a_done = 1'b0;
      wcnt = 0;
    end
    if (auto_bus && op_req && !rst) begin
      wcnt++;
      if (wcnt >= 2 + lat) begin
        a_din = 16'($urandom);
        if (exp_ops.size() == 0) begin
          chk("op_unexpected", op_req, 0);
        end else begin
          e = exp_ops.pop_front();
          chk("op_rw_sz_a", {op_rw, op_sz, op_a}, {e.rw, e.sz, e.a});
          if (e.rw) exp_rd.push_back(a_din);
          else chk("op_d", op_d, e.d);
        end
        a_done = 1'b1;
        lat = $urandom_range(0, 3);
      end
    end else begin
      wcnt = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] ga;
    logic        grw;
    logic [15:0] gd;
    logic        r_rw;
    int          base;
    int          n;
    int          nf;
    int          nrd;

    // Reset values
    repeat (2) cyc();
    chk("rst_op_req", op_req, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_txn_busy", txn_busy, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_op_a", op_a, 0);
    chk("rst_op_d", op_d, 0);
    chk("rst_rd_data", rd_data, 0);
    rst = 1'b0;
    #1;
    chk("ready_before_edge", cmd_ready, 0);
    cyc();
    chk("ready_after_release", cmd_ready, 1);

    // Write then read: the read must not reach the bus before the write ends
    base = rd_pulses;
    send(1'b0, 1'b0, 24'hDFF180, 16'h1234);
`ifdef WRITE_POST_EN
    send(1'b1, 1'b1, 24'hBFE001, 16'h0000);
`endif
    bus_done(16'hDEAD, ga, grw, gd);
    chk("ord_w_a", ga, 24'hDFF180);
    chk("ord_w_rw", grw, 0);
    chk("ord_w_d", gd, 16'h1234);
`ifndef WRITE_POST_EN
    send(1'b1, 1'b1, 24'hBFE001, 16'h0000);
`endif
    bus_done(16'h00FF, ga, grw, gd);
    chk("ord_r_a", ga, 24'hBFE001);
    chk("ord_r_rw", grw, 1);
    chk("rret_valid", rd_valid, 1);
    chk("rret_data", rd_data, 16'h00FF);
    cyc();
    cyc();
    chk("rd_pulse_once", rd_pulses - base, 1);

`ifndef WRITE_POST_EN
    // Unposted write: busy from accept through its OP_DONE cycle, no RD_VALID
    base = rd_pulses;
    send(1'b0, 1'b0, 24'h000200, 16'hAAAA);
    chk("np_busy_accept", txn_busy, 1);
    chk("np_ready_low", cmd_ready, 0);
    repeat (3) begin
      cyc();
      chk("np_busy_hold", txn_busy, 1);
    end
    chk("np_op_d", op_d, 16'hAAAA);
    m_done = 1'b1;
    chk("np_busy_done", txn_busy, 1);
    cyc();
    m_done = 1'b0;
    chk("np_busy_clear", txn_busy, 0);
    chk("np_ready_back", cmd_ready, 1);
    cyc();
    chk("np_no_rd", rd_pulses - base, 0);
`else
    // Four posted writes back-to-back fill the FIFO
    for (int i = 0; i < 4; i++) send(1'b0, 1'b0, 24'(32'h100 + 2 * i), 16'(i));
    chk("post_ready_full", cmd_ready, 0);
    for (int i = 0; i < 4; i++) begin
      bus_done(16'h0, ga, grw, gd);
      chk("post_order", ga, 24'(32'h100 + 2 * i));
      if (i == 0) chk("post_ready_after_done", cmd_ready, 1);
    end

    // Push and pop in the same cycle at count 2, across pointer wrap
    send(1'b0, 1'b0, 24'h000200, 16'h0005);
    send(1'b0, 1'b0, 24'h000202, 16'h0006);
    cyc();
    ga = op_a;
    cmd_valid = 1'b1;
    cmd_rw = 1'b0;
    cmd_sz = 1'b0;
    cmd_a = 24'h000204;
    cmd_d = 16'h0007;
    m_done = 1'b1;
    chk("pp_ready", cmd_ready, 1);
    chk("pp_head", ga, 24'h000200);
    cyc();
    cmd_valid = 1'b0;
    m_done = 1'b0;
    send(1'b0, 1'b0, 24'h000206, 16'h0008);
    chk("pp_ready_cnt3", cmd_ready, 1);
    send(1'b0, 1'b0, 24'h000208, 16'h0009);
    chk("pp_ready_cnt4", cmd_ready, 0);
    for (int i = 0; i < 4; i++) begin
      bus_done(16'h0, ga, grw, gd);
      chk("pp_order", ga, 24'(32'h202 + 2 * i));
    end
`endif

    // FLUSH while a write is on the bus
`ifdef WRITE_POST_EN
    nf = 3;
`else
    nf = 1;
`endif
    for (int i = 0; i < nf; i++) send(1'b0, 1'b0, 24'(32'h300 + 2 * i), 16'(i));
    n = 0;
    while (!op_req && n < 20) begin
      cyc();
      n++;
    end
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("fl_hold1", op_req, 1);
    cyc();
    chk("fl_hold2", op_req, 1);
    bus_done(16'h0, ga, grw, gd);
    chk("fl_head", ga, 24'h000300);
    for (int i = 0; i < 5; i++) begin
      chk("fl_idle", op_req, 0);
      cyc();
    end
    chk("fl_ready", cmd_ready, 1);
    chk("fl_busy", txn_busy, 0);

    // Reset in the middle of a bus cycle
    send(1'b0, 1'b0, 24'h000400, 16'h0001);
    n = 0;
    while (!op_req && n < 20) begin
      cyc();
      n++;
    end
    cyc();
    rst = 1'b1;
    #1;
    chk("amid_op_req", op_req, 0);
    chk("amid_busy", txn_busy, 0);
    cyc();
    rst = 1'b0;
    cyc();
    chk("amid_ready", cmd_ready, 1);
    cyc();
    chk("amid_abandon", op_req, 0);

    // Random traffic against the queue model
    auto_bus = 1'b1;
    base = rd_pulses;
    nrd = 0;
    for (int i = 0; i < 60; i++) begin
      r_rw = ($urandom_range(0, 2) == 0);
      send(r_rw, 1'($urandom_range(0, 1)), 24'($urandom), 16'($urandom));
      if (r_rw) nrd++;
      repeat ($urandom_range(0, 2)) cyc();
    end
    n = 0;
    while ((exp_ops.size() != 0 || exp_rd.size() != 0) && n < 3000) begin
      cyc();
      n++;
    end
    cyc();
    cyc();
    chk("rnd_ops_drained", exp_ops.size(), 0);
    chk("rnd_rd_drained", exp_rd.size(), 0);
    chk("rnd_rd_count", rd_pulses - base, nrd);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
